// File: rtl/product_accumulator_32_if.sv
// Product-in / sum-out handshake bundle for product_accumulator_32.
// The slave modport is the accumulator's view; the master modport is the source/sink's view.
interface product_accumulator_32_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 9
);
  logic [31:0]      prod_in;
  logic             prod_valid;
  logic             prod_last;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;
  logic             acc_forced;
  logic             acc_valid;
  logic             acc_ready;

  modport slave (
    input  prod_in, prod_valid, prod_last, acc_ready,
    output prod_ready, acc_out, acc_cnt, acc_ovf, acc_forced, acc_valid
  );

  modport master (
    output prod_in, prod_valid, prod_last, acc_ready,
    input  prod_ready, acc_out, acc_cnt, acc_ovf, acc_forced, acc_valid
  );
endinterface

// File: rtl/product_accumulator_32.sv
// Sums bursts of 32-bit unsigned products into an ACC_W-bit result with count/overflow flags.
// Define ACC_SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
module product_accumulator_32 #(
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  product_accumulator_32_if.slave bus
);

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             forced_q, forced_d;

  logic             beat;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   prod_ext;

  assign bus.prod_ready = (state_q == ST_ACC) && !rst;
  assign beat           = bus.prod_valid && bus.prod_ready;
  assign prod_ext       = {{(ACC_W + 1 - 32){1'b0}}, bus.prod_in};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    forced_d = forced_q;
    sum_ext  = '0;

    case (state_q)
      ST_ACC: begin
        if (beat) begin
          // First beat of a burst replaces the previous burst's sum.
          if (cnt_q == '0) begin
            sum_ext = prod_ext;
          end else begin
            sum_ext = {1'b0, acc_q} + prod_ext;
          end
`ifdef ACC_SATURATE_EN
          acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_d = sum_ext[ACC_W-1:0];
`endif
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + 1'b1;
          if (bus.prod_last) begin
            state_d  = ST_HOLD;
            forced_d = 1'b0;
          end else if (cnt_q == CNT_W'(MAX_TERMS - 1)) begin
            state_d  = ST_HOLD;
            forced_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.acc_ready) begin
          state_d  = ST_ACC;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          forced_d = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      forced_q <= forced_d;
    end
  end

  assign bus.acc_out    = acc_q;
  assign bus.acc_cnt    = cnt_q;
  assign bus.acc_ovf    = ovf_q;
  assign bus.acc_forced = forced_q;
  assign bus.acc_valid  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_product_accumulator_32.sv
// Directed and randomized checks of product_accumulator_32 (ACC_W=33, MAX_TERMS=4)
// against a burst-sum reference model computed with plain 64-bit arithmetic.
module tb_product_accumulator_32;

  localparam int ACC_W     = 33;
  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = 3;
  localparam longint unsigned LIM = 64'd1 << ACC_W;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  product_accumulator_32_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  product_accumulator_32 #(
    .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: the current burst is just its term count and true sum.
  bit              holding  = 1'b0;
  bit              forced_m = 1'b0;
  int              n_terms  = 0;
  longint unsigned sum_m    = 0;
  longint unsigned last_out = 0;

  function automatic longint unsigned acc_of(longint unsigned s);
`ifdef ACC_SATURATE_EN
    return (s >= LIM) ? LIM - 1 : s;
`else
    return s % LIM;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("prod_ready", 64'(bus.prod_ready), 64'(!holding && !rst));
    chk("acc_valid",  64'(bus.acc_valid),  64'(holding));
    chk("acc_cnt",    64'(bus.acc_cnt),    64'(n_terms));
    chk("acc_out",    64'(bus.acc_out),    (n_terms > 0) ? acc_of(sum_m) : last_out);
    chk("acc_ovf",    64'(bus.acc_ovf),    64'(n_terms > 0 && sum_m >= LIM));
    chk("acc_forced", 64'(bus.acc_forced), 64'(holding && forced_m));
  endtask

  // One clock: predict what the edge does from the driven inputs, then compare.
  task automatic tick();
    bit              r    = rst;
    bit              beat = !rst && !holding && bus.prod_valid;
    bit              hs   = !rst && holding && bus.acc_ready;
    bit              last = bus.prod_last;
    longint unsigned din  = 64'(bus.prod_in);
    @(posedge clk);
    #1;
    if (r) begin
      holding = 0; forced_m = 0; n_terms = 0; sum_m = 0; last_out = 0;
    end else if (beat) begin
      sum_m += din;
      n_terms++;
      if (last) begin
        holding = 1; forced_m = 0;
      end else if (n_terms == MAX_TERMS) begin
        holding = 1; forced_m = 1;
      end
    end else if (hs) begin
      $display("result: cnt=%0d sum=%0h ovf=%0d forced=%0d",
               n_terms, acc_of(sum_m), sum_m >= LIM, forced_m);
      last_out = acc_of(sum_m);
      sum_m = 0; n_terms = 0; holding = 0; forced_m = 0;
    end
    check_outputs();
  endtask

  // Present one beat and hold it until the model says it was taken (bounded).
  task automatic send(logic [31:0] data, bit last);
    int guard = 0;
    bit took;
    bus.prod_valid = 1'b1;
    bus.prod_in    = data;
    bus.prod_last  = last;
    do begin
      took = !rst && !holding;
      tick();
      guard++;
    end while (!took && guard < 50);
    chk("send_accepted", 64'(took), 64'd1);
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
  endtask

  initial begin
    bit pending = 1'b0;
    bit accept;
    rst            = 1'b1;
    bus.prod_in    = '0;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    bus.acc_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic three-term burst, result for exactly one cycle.
    bus.acc_ready = 1'b1;
    send(32'd3, 1'b0);
    send(32'd5, 1'b0);
    send(32'd7, 1'b1);
    chk("t1_sum",    64'(bus.acc_out),    64'd15);
    chk("t1_cnt",    64'(bus.acc_cnt),    64'd3);
    chk("t1_ovf",    64'(bus.acc_ovf),    64'd0);
    chk("t1_forced", 64'(bus.acc_forced), 64'd0);
    chk("t1_valid",  64'(bus.acc_valid),  64'd1);
    tick();
    chk("t1_valid_drop", 64'(bus.acc_valid), 64'd0);

    // Single-term burst; following burst must not inherit the old sum.
    send(32'hFFFE_0001, 1'b1);
    chk("t2_sum", 64'(bus.acc_out), 64'hFFFE_0001);
    chk("t2_cnt", 64'(bus.acc_cnt), 64'd1);
    tick();
    send(32'd2, 1'b1);
    chk("t2_fresh", 64'(bus.acc_out), 64'd2);
    tick();

    // Overflow at ACC_W=33.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
`ifdef ACC_SATURATE_EN
    chk("t3_sum", 64'(bus.acc_out), 64'h1_FFFF_FFFF);
`else
    chk("t3_sum", 64'(bus.acc_out), 64'h0_FFFF_FFFD);
`endif
    chk("t3_ovf", 64'(bus.acc_ovf), 64'd1);
    tick();

    // Force-close at MAX_TERMS; the next beats stall until the handshake.
    bus.acc_ready = 1'b0;
    repeat (4) send(32'd1, 1'b0);
    chk("t4_cnt",    64'(bus.acc_cnt),    64'd4);
    chk("t4_sum",    64'(bus.acc_out),    64'd4);
    chk("t4_forced", 64'(bus.acc_forced), 64'd1);
    bus.prod_valid = 1'b1;
    bus.prod_in    = 32'd1;
    repeat (3) tick();
    chk("t4_stall", 64'(bus.prod_ready), 64'd0);
    bus.acc_ready = 1'b1;
    send(32'd1, 1'b0);
    send(32'd1, 1'b0);
    chk("t4_cnt2", 64'(bus.acc_cnt), 64'd2);
    send(32'd1, 1'b1);
    chk("t4_sum2", 64'(bus.acc_out), 64'd3);
    tick();

    // Back-pressure in HOLD for 10 cycles, then exactly one handshake.
    bus.acc_ready = 1'b0;
    send(32'd10, 1'b1);
    repeat (10) begin
      tick();
      chk("t5_hold_sum", 64'(bus.acc_out), 64'd10);
    end
    bus.acc_ready = 1'b1;
    tick();
    chk("t5_released", 64'(bus.acc_valid), 64'd0);
    tick();
    chk("t5_single", 64'(bus.acc_valid), 64'd0);

    // Reset mid-burst discards everything.
    send(32'd4, 1'b0);
    send(32'd6, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_out",   64'(bus.acc_out),   64'd0);
    chk("t6_cnt",   64'(bus.acc_cnt),   64'd0);
    chk("t6_valid", 64'(bus.acc_valid), 64'd0);
    rst = 1'b0;
    tick();
    send(32'd9, 1'b1);
    chk("t6_sum", 64'(bus.acc_out), 64'd9);
    tick();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending        = 1'b1;
        bus.prod_in    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        bus.prod_last  = ($urandom_range(0, 4) == 0);
      end
      bus.prod_valid = pending;
      bus.acc_ready  = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 149) == 0);
      accept         = !rst && !holding && pending;
      tick();
      if (accept) pending = 1'b0;
    end
    rst            = 1'b0;
    bus.prod_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
